// File: rtl/fetch.sv
// 6502 instruction fetch: reads opcode plus 0-2 operand bytes over a byte-wide port and hands decode one assembled instruction.
// Optional opcode legality flag enabled by defining FETCH_ILLEGAL_DETECT_EN.
module fetch #(
  parameter int MEM_ADDR_SIZE = 16,
  parameter int DATA_W        = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [MEM_ADDR_SIZE-1:0] pc_i,
  output logic                     pc_adv_o,
  output logic [1:0]               pc_adv_len_o,
  input  logic                     flush_i,
  output logic                     mem_req_o,
  output logic [MEM_ADDR_SIZE-1:0] mem_addr_o,
  input  logic                     mem_gnt_i,
  input  logic                     mem_rvalid_i,
  input  logic [DATA_W-1:0]        mem_rdata_i,
  output logic                     instr_valid_o,
  input  logic                     instr_ready_i,
  output logic [DATA_W-1:0]        instr_opcode_o,
  output logic [2*DATA_W-1:0]      instr_operand_o,
  output logic [1:0]               instr_len_o,
  output logic [MEM_ADDR_SIZE-1:0] instr_pc_o,
  output logic                     illegal_o
);

  typedef enum logic [2:0] {S_OP, S_OPR1, S_OPR2, S_OUT, S_DRAIN} state_t;

  state_t                   state_q, state_d;
  logic                     req_en_q;
  logic                     out_q;
  logic [MEM_ADDR_SIZE-1:0] base_q;
  logic [DATA_W-1:0]        opcode_q;
  logic [DATA_W-1:0]        byte1_q;
  logic [DATA_W-1:0]        byte2_q;
  logic [1:0]               len_q;
  logic                     rsp;
  logic                     grant;

  function automatic logic [1:0] len_of(input logic [7:0] op);
    logic [1:0] l;
    case (op[3:0])
      4'h0: begin
        if (op == 8'h20) l = 2'd3;
        else if (op == 8'h00 || op == 8'h40 || op == 8'h60) l = 2'd1;
        else l = 2'd2;
      end
      4'h1, 4'h4, 4'h5, 4'h6: l = 2'd2;
      4'h2:                   l = (op == 8'hA2) ? 2'd2 : 2'd1;
      4'h8, 4'hA:             l = 2'd1;
      4'h9:                   l = op[4] ? 2'd3 : 2'd2;
      4'hC, 4'hD, 4'hE:       l = 2'd3;
      default:                l = 2'd1;
    endcase
    return l;
  endfunction

  // Response only counts when a granted read is outstanding; stray rvalids are ignored.
  assign rsp   = out_q && mem_rvalid_i;
  assign grant = mem_req_o && mem_gnt_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_OP;
      req_en_q <= 1'b0;
      out_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_en_q <= 1'b1;
      if (grant)    out_q <= 1'b1;
      else if (rsp) out_q <= 1'b0;
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_req_o     = 1'b0;
    mem_addr_o    = '0;
    instr_valid_o = 1'b0;
    pc_adv_o      = 1'b0;
    pc_adv_len_o  = 2'd0;

    if (req_en_q && !out_q) begin
      case (state_q)
        S_OP: begin
          mem_req_o  = 1'b1;
          mem_addr_o = pc_i;
        end
        S_OPR1: begin
          mem_req_o  = 1'b1;
          mem_addr_o = base_q + MEM_ADDR_SIZE'(1);
        end
        S_OPR2: begin
          mem_req_o  = 1'b1;
          mem_addr_o = base_q + MEM_ADDR_SIZE'(2);
        end
        default: ;
      endcase
    end

    case (state_q)
      S_OP:    if (rsp) state_d = (len_of(mem_rdata_i) == 2'd1) ? S_OUT : S_OPR1;
      S_OPR1:  if (rsp) state_d = (len_q == 2'd2) ? S_OUT : S_OPR2;
      S_OPR2:  if (rsp) state_d = S_OUT;
      S_OUT: begin
        instr_valid_o = 1'b1;
        if (instr_ready_i) begin
          pc_adv_o     = 1'b1;
          pc_adv_len_o = len_q;
          state_d      = S_OP;
        end
      end
      S_DRAIN: if (rsp) state_d = S_OP;
      default: state_d = S_OP;
    endcase

    // A granted read whose data has not returned must be drained before refetching.
    if (flush_i) begin
      pc_adv_o     = 1'b0;
      pc_adv_len_o = 2'd0;
      state_d      = ((out_q && !mem_rvalid_i) || grant) ? S_DRAIN : S_OP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q   <= '0;
      opcode_q <= '0;
      byte1_q  <= '0;
      byte2_q  <= '0;
      len_q    <= 2'd0;
    end else if (flush_i) begin
      opcode_q <= '0;
      byte1_q  <= '0;
      byte2_q  <= '0;
      len_q    <= 2'd0;
    end else begin
      if (state_q == S_OP && grant) base_q <= pc_i;
      if (rsp) begin
        case (state_q)
          S_OP: begin
            opcode_q <= mem_rdata_i;
            len_q    <= len_of(mem_rdata_i);
          end
          S_OPR1:  byte1_q <= mem_rdata_i;
          S_OPR2:  byte2_q <= mem_rdata_i;
          default: ;
        endcase
      end
      if (state_q == S_OUT && instr_ready_i) begin
        byte1_q <= '0;
        byte2_q <= '0;
      end
    end
  end

`ifdef FETCH_ILLEGAL_DETECT_EN
  logic illegal_q;

  function automatic logic illegal_of(input logic [7:0] op);
    logic il;
    case (op[3:0])
      4'h3, 4'h7, 4'hB, 4'hF: il = 1'b1;
      4'h2:                   il = (op != 8'hA2);
      default:                il = 1'b0;
    endcase
    return il;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          illegal_q <= 1'b0;
    else if (flush_i)                 illegal_q <= 1'b0;
    else if (rsp && state_q == S_OP)  illegal_q <= illegal_of(mem_rdata_i);
  end

  assign illegal_o = illegal_q;
`else
  assign illegal_o = 1'b0;
`endif

  assign instr_opcode_o  = opcode_q;
  assign instr_operand_o = {byte2_q, byte1_q};
  assign instr_len_o     = len_q;
  assign instr_pc_o      = base_q;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: hand-driven memory handshakes with hand-computed expectations.
module tb_fetch;
  logic        clk;
  logic        rst;
  logic [15:0] pc_i;
  logic        pc_adv_o;
  logic [1:0]  pc_adv_len_o;
  logic        flush_i;
  logic        mem_req_o;
  logic [15:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [7:0]  mem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [7:0]  instr_opcode_o;
  logic [15:0] instr_operand_o;
  logic [1:0]  instr_len_o;
  logic [15:0] instr_pc_o;
  logic        illegal_o;

  int checks = 0;
  int errors = 0;
  logic exp_illegal;

  fetch dut (
    .clk(clk), .rst(rst), .pc_i(pc_i),
    .pc_adv_o(pc_adv_o), .pc_adv_len_o(pc_adv_len_o), .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_opcode_o(instr_opcode_o), .instr_operand_o(instr_operand_o),
    .instr_len_o(instr_len_o), .instr_pc_o(instr_pc_o), .illegal_o(illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One read with same-cycle grant and next-cycle data.
  task automatic mem_read(input logic [15:0] a, input logic [7:0] d, input string tag);
    #1;
    chk({tag, "_req"}, 32'(mem_req_o), 32'd1);
    chk({tag, "_addr"}, 32'(mem_addr_o), 32'(a));
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = d;
    #1;
    chk({tag, "_noreq"}, 32'(mem_req_o), 32'd0);
    tick();
    mem_rvalid_i = 1'b0;
    #1;
  endtask

  initial begin
`ifdef FETCH_ILLEGAL_DETECT_EN
    exp_illegal = 1'b1;
`else
    exp_illegal = 1'b0;
`endif
    rst = 1'b1; pc_i = 16'h8000; flush_i = 1'b0; mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0; mem_rdata_i = 8'h00; instr_ready_i = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_addr", 32'(mem_addr_o), 32'd0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_pcadv", 32'(pc_adv_o), 32'd0);
    chk("rst_pcadvlen", 32'(pc_adv_len_o), 32'd0);
    chk("rst_opcode", 32'(instr_opcode_o), 32'd0);
    chk("rst_len", 32'(instr_len_o), 32'd0);
    chk("rst_pc", 32'(instr_pc_o), 32'd0);
    chk("rst_illegal", 32'(illegal_o), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_noreq", 32'(mem_req_o), 32'd0);
    tick();

    // NOP at 0x8000
    mem_read(16'h8000, 8'hEA, "nop_op");
    chk("nop_valid", 32'(instr_valid_o), 32'd1);
    chk("nop_opcode", 32'(instr_opcode_o), 32'hEA);
    chk("nop_len", 32'(instr_len_o), 32'd1);
    chk("nop_pc", 32'(instr_pc_o), 32'h8000);
    chk("nop_operand", 32'(instr_operand_o), 32'd0);
    chk("nop_pcadv", 32'(pc_adv_o), 32'd1);
    chk("nop_pcadvlen", 32'(pc_adv_len_o), 32'd1);
    tick();
    chk("nop_after_valid", 32'(instr_valid_o), 32'd0);
    chk("nop_after_pcadv", 32'(pc_adv_o), 32'd0);

    // JMP $1234
    pc_i = 16'h8000;
    mem_read(16'h8000, 8'h4C, "jmp_op");
    mem_read(16'h8001, 8'h34, "jmp_b1");
    mem_read(16'h8002, 8'h12, "jmp_b2");
    chk("jmp_valid", 32'(instr_valid_o), 32'd1);
    chk("jmp_opcode", 32'(instr_opcode_o), 32'h4C);
    chk("jmp_operand", 32'(instr_operand_o), 32'h1234);
    chk("jmp_len", 32'(instr_len_o), 32'd3);
    chk("jmp_pcadv", 32'(pc_adv_o), 32'd1);
    chk("jmp_pcadvlen", 32'(pc_adv_len_o), 32'd3);
    tick();
    chk("jmp_after_operand", 32'(instr_operand_o), 32'd0);

    // LDA #$55 at 0xFFFF wraps operand read to 0x0000; decoder stalls
    instr_ready_i = 1'b0;
    pc_i = 16'hFFFF;
    mem_read(16'hFFFF, 8'hA9, "lda_op");
    mem_read(16'h0000, 8'h55, "lda_b1");
    chk("lda_valid", 32'(instr_valid_o), 32'd1);
    chk("lda_operand", 32'(instr_operand_o), 32'h0055);
    chk("lda_len", 32'(instr_len_o), 32'd2);
    chk("lda_pc", 32'(instr_pc_o), 32'hFFFF);
    for (int i = 0; i < 5; i++) begin
      mem_rvalid_i = (i == 2);
      mem_rdata_i  = 8'h77;
      #1;
      chk("stall_valid", 32'(instr_valid_o), 32'd1);
      chk("stall_opcode", 32'(instr_opcode_o), 32'hA9);
      chk("stall_operand", 32'(instr_operand_o), 32'h0055);
      chk("stall_noreq", 32'(mem_req_o), 32'd0);
      chk("stall_pcadv", 32'(pc_adv_o), 32'd0);
      tick();
    end
    mem_rvalid_i = 1'b0;
    pc_i = 16'hC000;
    flush_i = 1'b1;
    instr_ready_i = 1'b1;
    #1;
    chk("flushrdy_pcadv", 32'(pc_adv_o), 32'd0);
    chk("flushrdy_pcadvlen", 32'(pc_adv_len_o), 32'd0);
    tick();
    flush_i = 1'b0;
    #1;
    chk("flushrdy_valid", 32'(instr_valid_o), 32'd0);
    chk("flushrdy_operand", 32'(instr_operand_o), 32'd0);

    // LDA abs, flush with byte1 read outstanding, data two cycles late
    mem_read(16'hC000, 8'hAD, "drain_op");
    chk("drain_b1_req", 32'(mem_req_o), 32'd1);
    chk("drain_b1_addr", 32'(mem_addr_o), 32'hC001);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    flush_i = 1'b1;
    #1;
    chk("drain_flush_noreq", 32'(mem_req_o), 32'd0);
    chk("drain_flush_pcadv", 32'(pc_adv_o), 32'd0);
    tick();
    flush_i = 1'b0;
    pc_i = 16'h9000;
    #1;
    chk("drain_wait_noreq", 32'(mem_req_o), 32'd0);
    chk("drain_wait_valid", 32'(instr_valid_o), 32'd0);
    chk("drain_wait_pcadv", 32'(pc_adv_o), 32'd0);
    tick();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 8'hFF;
    #1;
    chk("drain_late_noreq", 32'(mem_req_o), 32'd0);
    chk("drain_late_valid", 32'(instr_valid_o), 32'd0);
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    chk("drain_done_valid", 32'(instr_valid_o), 32'd0);
    chk("drain_done_pcadv", 32'(pc_adv_o), 32'd0);

    // Opcode 0x02 at new PC: length 1, legality depends on build
    mem_read(16'h9000, 8'h02, "ill_op");
    chk("ill_valid", 32'(instr_valid_o), 32'd1);
    chk("ill_opcode", 32'(instr_opcode_o), 32'h02);
    chk("ill_len", 32'(instr_len_o), 32'd1);
    chk("ill_pc", 32'(instr_pc_o), 32'h9000);
    chk("ill_operand", 32'(instr_operand_o), 32'd0);
    chk("ill_flag", 32'(illegal_o), 32'(exp_illegal));
    chk("ill_pcadv", 32'(pc_adv_o), 32'd1);
    chk("ill_pcadvlen", 32'(pc_adv_len_o), 32'd1);
    tick();
    chk("ill_after_valid", 32'(instr_valid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
